// File: rtl/gcd_datapath_if.sv
// gcd_datapath_if -- handshake/status bundle between the GCD control path
// and the GCD datapath.
//
//   X_in, Y_in       external operands for XR / YR
//   SelectXY         0 = external load path, 1 = internal swap/subtract path
//   LoadXR, LoadYR   load enables (LoadXR also qualifies a subtract)
//   Subtract, Swap   internal operation requests (Swap wins)
//   D0, D1           control-path state bits; 2'b11 is the done state
//   I0, I1, Zero     combinational status back to the control path
//   Result, Valid    captured GCD and its one-cycle update pulse
//   IterCount        internal operations since the last external load
//
// master = control path (drives requests), slave = datapath.
interface gcd_datapath_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] X_in;
    logic [WIDTH-1:0] Y_in;
    logic             SelectXY;
    logic             LoadXR;
    logic             LoadYR;
    logic             Subtract;
    logic             Swap;
    logic             D0;
    logic             D1;
    logic             I0;
    logic             I1;
    logic             Zero;
    logic [WIDTH-1:0] Result;
    logic             Valid;
    logic [15:0]      IterCount;

    modport master (
        output X_in, Y_in, SelectXY, LoadXR, LoadYR, Subtract, Swap, D0, D1,
        input  I0, I1, Zero, Result, Valid, IterCount
    );

    modport slave (
        input  X_in, Y_in, SelectXY, LoadXR, LoadYR, Subtract, Swap, D0, D1,
        output I0, I1, Zero, Result, Valid, IterCount
    );
endinterface

// File: rtl/gcd_datapath.sv
// gcd_datapath -- operand registers and status logic for a subtract/swap
// GCD engine driven by an external control path.
//
// Ports:
//   clk  rising-edge clock
//   rst  asynchronous, active-high reset
//   bus  gcd_datapath_if.slave: operands, load/swap/subtract requests and
//        control state in; status flags, Result/Valid and IterCount out.
//
// XR/YR are loaded externally (SelectXY=0) or exchanged / reduced
// internally (SelectXY=1, Swap over Subtract). Entering the done state
// {D1,D0}=11 captures XR into Result with a single-cycle Valid pulse.
module gcd_datapath #(
    parameter int WIDTH = 8
) (
    input  logic          clk,
    input  logic          rst,
    gcd_datapath_if.slave bus
);

    localparam logic [1:0]  DONE_STATE = 2'b11;
    localparam logic [15:0] ITER_MAX   = 16'hFFFF;

    logic [WIDTH-1:0] xr;
    logic [WIDTH-1:0] yr;
    logic [WIDTH-1:0] result_r;
    logic             valid_r;
    logic [15:0]      iter_r;
    logic [1:0]       state_prev;

    logic [1:0]       state_now;
    logic             do_swap;
    logic             do_sub;
    logic             ext_load;
    logic             enter_done;

    // Saturating increment: the counter parks at all-ones instead of wrapping.
    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == ITER_MAX) ? ITER_MAX : v + 16'd1;
    endfunction

    assign state_now  = {bus.D1, bus.D0};
    assign do_swap    = bus.SelectXY & bus.Swap;
    // A subtract only writes XR, so it is qualified by LoadXR.
    assign do_sub     = bus.SelectXY & ~bus.Swap & bus.Subtract & bus.LoadXR;
    assign ext_load   = ~bus.SelectXY & (bus.LoadXR | bus.LoadYR);
    assign enter_done = (state_now == DONE_STATE) && (state_prev != DONE_STATE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            xr         <= '0;
            yr         <= '0;
            result_r   <= '0;
            valid_r    <= 1'b0;
            iter_r     <= '0;
            state_prev <= 2'b00;
        end else begin
            if (do_swap) begin
                xr <= yr;
                yr <= xr;
            end else if (do_sub) begin
                xr <= xr - yr;
            end else if (!bus.SelectXY) begin
                if (bus.LoadXR) xr <= bus.X_in;
                if (bus.LoadYR) yr <= bus.Y_in;
            end

            // A fresh load restarts the count even if an op lands the same edge.
            if (ext_load) begin
                iter_r <= '0;
            end else if (do_swap || do_sub) begin
                iter_r <= sat_inc(iter_r);
            end

            // Edge-detect on the done state so a held 11 yields one pulse only.
            state_prev <= state_now;
            valid_r    <= enter_done;
            if (enter_done) begin
                result_r <= xr;
            end
        end
    end

    assign bus.I0        = (xr != yr);
    assign bus.I1        = (xr < yr);
    assign bus.Zero      = (xr == '0) || (yr == '0);
    assign bus.Result    = result_r;
    assign bus.Valid     = valid_r;
    assign bus.IterCount = iter_r;

endmodule
